// File: rtl/fp_accum.sv
// Streaming float accumulator wrapped around an external combinational FP adder.
// The adder sees only registered operands; results are returned via valid/ready.
module fp_accum #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             busy,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ACCUM,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      opb_q, opb_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_r_q, len_r_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             in_hs;
  logic [LEN_W-1:0] cnt_inc;

  // The adder works on magnitudes only, so every stored operand is forced positive.
  function automatic logic [31:0] strip_sign(input logic [31:0] f);
    return f & 32'h7FFF_FFFF;
  endfunction

  assign in_hs   = in_valid && in_ready_q;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    len_r_d = len_r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_r_d = len;
          cnt_d   = '0;
          if (len == '0) begin
            acc_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        // First element is loaded rather than added: the adder cannot take a zero operand.
        if (in_hs) begin
          acc_d   = strip_sign(in_data);
          cnt_d   = LEN_W'(1);
          state_d = (len_r_q == LEN_W'(1)) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_hs) begin
          opb_d   = strip_sign(in_data);
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = add_s;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_r_q) ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      len_r_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      len_r_q     <= len_r_d;
      in_ready_q  <= (state_d == S_FIRST) || (state_d == S_ACCUM);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = out_valid_q ? acc_q : 32'h0;
  assign add_a     = acc_q;
  assign add_b     = opb_q;

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum with a behavioural positive-float adder on add_a/add_b.
module tb_fp_accum;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             busy;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_s;

  int n_cmp = 0;
  int n_err = 0;

  fp_accum #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_s    (add_s)
  );

  always #5 clk = ~clk;

  // Truncating adder for positive normalized singles (stand-in for the real adder).
  function automatic logic [31:0] fpadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    logic [7:0]  ex, d;
    logic [23:0] mx, my;
    logic [24:0] s;
    if (x[30:23] < y[30:23]) begin
      t = x; x = y; y = t;
    end
    ex = x[30:23];
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0]};
    my = (d > 8'd23) ? 24'd0 : ({1'b1, y[22:0]} >> d);
    s  = {1'b0, mx} + {1'b0, my};
    if (s[24]) return {1'b0, ex + 8'd1, s[23:1]};
    else       return {1'b0, ex, s[22:0]};
  endfunction

  always_comb add_s = fpadd(add_a, add_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] vals [5];
  logic [15:0] gap;
  logic [31:0] held;
  int          idx;
  logic        take;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    #12 reset_n = 1'b1;
    step();

    // Two elements, in_valid held high: start sampled at edge 1, result after edge 4.
    start = 1'b1; len = 8'd2; in_valid = 1'b1; in_data = 32'h3F800000;
    step();
    start = 1'b0;
    chk("l2_busy", {31'd0, busy}, 32'd1);
    chk("l2_ready_first", {31'd0, in_ready}, 32'd1);
    step();
    in_data = 32'h40000000;
    chk("l2_acc_first", add_a, 32'h3F800000);
    step();
    chk("l2_ready_add", {31'd0, in_ready}, 32'd0);
    chk("l2_add_b", add_b, 32'h40000000);
    chk("l2_valid_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("l2_valid", {31'd0, out_valid}, 32'd1);
    chk("l2_sum", out_sum, 32'h40400000);
    drain();

    // Three elements: 1.0 + 0.5 + 1.5.
    start = 1'b1; len = 8'd3; in_data = 32'h3F800000;
    step();
    start = 1'b0;
    step();
    in_data = 32'h3F000000;
    step();
    in_data = 32'h3FC00000;
    chk("l3_ready_add1", {31'd0, in_ready}, 32'd0);
    step();
    chk("l3_acc_after_add1", add_a, 32'h3FC00000);
    step();
    step();
    chk("l3_valid", {31'd0, out_valid}, 32'd1);
    chk("l3_sum", out_sum, 32'h40400000);
    drain();

    // len = 0: immediate DONE with zero, never ready for input.
    start = 1'b1; len = 8'd0; in_data = 32'h40000000;
    chk("l0_ready_idle", {31'd0, in_ready}, 32'd0);
    step();
    start = 1'b0;
    chk("l0_valid", {31'd0, out_valid}, 32'd1);
    chk("l0_sum", out_sum, 32'h0);
    chk("l0_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // len = 1 passes the element through unchanged.
    start = 1'b1; len = 8'd1; in_data = 32'h40490FDB;
    step();
    start = 1'b0;
    step();
    chk("l1_valid", {31'd0, out_valid}, 32'd1);
    chk("l1_sum", out_sum, 32'h40490FDB);
    drain();

    // Sign strip on a negative input.
    start = 1'b1; len = 8'd1; in_data = 32'hBF800000;
    step();
    start = 1'b0;
    step();
    chk("sign_sum", out_sum, 32'h3F800000);
    drain();

    // Handshake stress: 1+2+4+8 with input gaps, a surplus element offered, output stalled.
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40800000;
    vals[3] = 32'h41000000; vals[4] = 32'h42C80000;
    gap = 16'b0110_1001_1101_0011;
    idx = 0;
    start = 1'b1; len = 8'd4; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 64 && !out_valid; c++) begin
      in_valid = gap[c % 16];
      in_data  = vals[(idx > 4) ? 4 : idx];
      take     = in_valid && in_ready;
      step();
      if (take) idx++;
    end
    chk("st_valid", {31'd0, out_valid}, 32'd1);
    chk("st_accepted", idx, 32'd4);
    chk("st_sum", out_sum, 32'h41700000);
    held = out_sum;
    in_valid = 1'b1;
    in_data  = vals[4];
    start    = 1'b1;
    len      = 8'd1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("st_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("st_hold_sum", out_sum, held);
      chk("st_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0;
    drain();
    step();
    chk("st_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-sum while in ACCUM aborts asynchronously.
    start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 32'h3F800000;
    step();
    start = 1'b0;
    step();
    in_data = 32'h40000000;
    chk("mr_acc_before", add_a, 32'h3F800000);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_sum", out_sum, 32'h0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_add_a", add_a, 32'h0);
    chk("mr_add_b", add_b, 32'h0);
    #2 reset_n = 1'b1;
    step();
    chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; len = 8'd1; in_data = 32'h3F800000;
    step();
    start = 1'b0;
    step();
    chk("mr_after_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_after_sum", out_sum, 32'h3F800000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
